// File: rtl/sprite_fetch.sv
// sprite_fetch: per-scanline sprite pattern fetch over PPU cycles 256-319,
// eight 8-cycle slots each producing one load into the sprite shift-register set.
module sprite_fetch #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              ce,
    input  logic [8:0]        i_cycle,
    input  logic              i_sprites_enabled,
    input  logic              i_obj_size,
    input  logic              i_pt_sel,
    input  logic [7:0]        i_oam_bus,
    output logic [ADDR_W-1:0] o_vram_addr,
    output logic              o_vram_rd,
    input  logic [7:0]        i_vram_data,
    output logic [3:0]        o_load,
    output logic [26:0]       o_load_out
);
    logic        in_win, plane;
    logic [2:0]  k;
    logic [3:0]  row_q, row_d, erow;
    logic        empty_q, empty_d, valid_q, valid_d, rd_q, rd_d;
    logic [7:0]  tile_q, tile_d, x_q, x_d, low_q, low_d, rev, pix;
    logic [4:0]  attr_q, attr_d;
    logic [3:0]  load_q, load_d;
    logic [26:0] out_q, out_d;
    logic [13:0] addr;

    assign in_win = (i_cycle >= 9'd256) && (i_cycle <= 9'd319);
    assign k      = i_cycle[2:0];
    assign plane  = k[1];
    // attr_q packs {vflip, hflip, priority, palette[1:0]}
    assign erow = attr_q[4] ? ((i_obj_size ? 4'd15 : 4'd7) - row_q) : row_q;
    assign addr = i_obj_size ? {1'b0, tile_q[0], tile_q[7:1], erow[3], plane, erow[2:0]}
                             : {1'b0, i_pt_sel, tile_q, plane, erow[2:0]};
    assign o_vram_rd   = in_win && k[2] && !k[0] && valid_q && !empty_q && i_sprites_enabled;
    assign o_vram_addr = o_vram_rd ? addr : '0;
    assign o_load      = load_q;
    assign o_load_out  = out_q;

    always_comb begin
        for (int i = 0; i < 8; i++) rev[i] = i_vram_data[7-i];
    end

    // A plane with no read issued in its fetch cycle contributes zero pixels.
    assign pix = rd_q ? (attr_q[3] ? i_vram_data : rev) : 8'h00;

    always_comb begin
        row_d   = row_q;
        empty_d = empty_q;
        valid_d = valid_q;
        tile_d  = tile_q;
        attr_d  = attr_q;
        x_d     = x_q;
        rd_d    = rd_q;
        low_d   = low_q;
        load_d  = 4'h0;
        out_d   = out_q;
        if (in_win) begin
            case (k)
                3'd0: begin
                    row_d   = i_oam_bus[3:0];
                    empty_d = |i_oam_bus[7:4];
                    valid_d = 1'b1;
                end
                3'd1: tile_d = i_oam_bus;
                3'd2: attr_d = {i_oam_bus[7:5], i_oam_bus[1:0]};
                3'd3: x_d = i_oam_bus;
                3'd4, 3'd6: rd_d = o_vram_rd;
                3'd5: low_d = pix;
                default: begin
                    if (valid_q) begin
                        load_d = 4'hF;
                        out_d  = {low_q, pix, x_q, attr_q[1:0], attr_q[2]};
                    end
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            row_q   <= '0;
            empty_q <= 1'b0;
            valid_q <= 1'b0;
            tile_q  <= '0;
            attr_q  <= '0;
            x_q     <= '0;
            rd_q    <= 1'b0;
            low_q   <= '0;
            load_q  <= '0;
            out_q   <= '0;
        end else if (ce) begin
            row_q   <= row_d;
            empty_q <= empty_d;
            valid_q <= valid_d;
            tile_q  <= tile_d;
            attr_q  <= attr_d;
            x_q     <= x_d;
            rd_q    <= rd_d;
            low_q   <= low_d;
            load_q  <= load_d;
            out_q   <= out_d;
        end
    end
endmodule

// File: tb/tb_sprite_fetch.sv
// tb_sprite_fetch: directed scanline scenarios for sprite_fetch with
// hand-computed fetch addresses and load words.
module tb_sprite_fetch;
    logic        clk = 1'b0;
    logic        i_rst, ce, i_sprites_enabled, i_obj_size, i_pt_sel, o_vram_rd;
    logic [8:0]  i_cycle;
    logic [7:0]  i_oam_bus, i_vram_data;
    logic [13:0] o_vram_addr;
    logic [3:0]  o_load;
    logic [26:0] o_load_out;
    int checks = 0, failures = 0;

    logic [7:0]  ty[8], tt[8], ta[8], tx[8], dlo[8], dhi[8];
    logic [13:0] ea0[8], ea1[8];
    logic [26:0] eo[8];
    bit          erd[8], eld[8];

    sprite_fetch dut (
        .clk(clk), .i_rst(i_rst), .ce(ce), .i_cycle(i_cycle),
        .i_sprites_enabled(i_sprites_enabled), .i_obj_size(i_obj_size),
        .i_pt_sel(i_pt_sel), .i_oam_bus(i_oam_bus), .o_vram_addr(o_vram_addr),
        .o_vram_rd(o_vram_rd), .i_vram_data(i_vram_data), .o_load(o_load),
        .o_load_out(o_load_out)
    );

    always #5 clk = ~clk;

    task automatic fill_empty(input logic [7:0] attr);
        for (int s = 0; s < 8; s++) begin
            ty[s] = 8'hFF; tt[s] = 8'h00; ta[s] = attr; tx[s] = 8'h20 + 8'(s);
            dlo[s] = 8'hA5; dhi[s] = 8'h3C;
            erd[s] = 1'b0; eld[s] = 1'b1; ea0[s] = '0; ea1[s] = '0;
            eo[s] = {16'h0, tx[s], attr[1:0], attr[5]};
        end
    endtask

    task automatic run_line(input int div, input int rst_at);
        int loads, want;
        loads = 0;
        want = 0;
        for (int s = 0; s < 8; s++) if (eld[s]) want++;
        for (int cyc = 250; cyc < 330; cyc++) begin
            int s, k, ls;
            bit win, ldc;
            logic [3:0] ld_exp;
            win = cyc >= 256 && cyc < 320;
            s = win ? (cyc - 256) / 8 : 0;
            k = win ? (cyc - 256) % 8 : 0;
            ldc = cyc >= 264 && cyc <= 320 && (cyc % 8) == 0;
            ls = ldc ? (cyc - 264) / 8 : 0;
            ld_exp = (ldc && eld[ls]) ? 4'hF : 4'h0;
            i_cycle = 9'(cyc);
            i_oam_bus = !win ? 8'hEE : k == 0 ? ty[s] : k == 1 ? tt[s] : k == 2 ? ta[s] : k == 3 ? tx[s] : 8'hEE;
            i_vram_data = (win && k == 5) ? dlo[s] : (win && k == 7) ? dhi[s] : 8'h5A;
            #1;
            if (win && (k == 4 || k == 6)) begin
                checks++;
                if (o_vram_rd !== erd[s]) begin
                    failures++;
                    $display("FAIL rd cyc=%0d got=%b want=%b", cyc, o_vram_rd, erd[s]);
                end
                checks++;
                if (o_vram_addr !== (erd[s] ? (k == 4 ? ea0[s] : ea1[s]) : 14'h0)) begin
                    failures++;
                    $display("FAIL addr cyc=%0d got=%h want=%h", cyc, o_vram_addr,
                             erd[s] ? (k == 4 ? ea0[s] : ea1[s]) : 14'h0);
                end
            end
            if (!win && cyc != 320) begin
                checks++;
                if (o_vram_rd !== 1'b0) begin
                    failures++;
                    $display("FAIL rd_outside cyc=%0d got=%b want=0", cyc, o_vram_rd);
                end
            end
            for (int n = 0; n < div; n++) begin
                checks++;
                if (o_load !== ld_exp) begin
                    failures++;
                    $display("FAIL load cyc=%0d n=%0d got=%h want=%h", cyc, n, o_load, ld_exp);
                end
                if (n == 0 && ld_exp != 0) begin
                    loads++;
                    checks++;
                    if (o_load_out !== eo[ls]) begin
                        failures++;
                        $display("FAIL load_out slot=%0d got=%h want=%h", ls, o_load_out, eo[ls]);
                    end
                end
                if (n == 0 && cyc == rst_at + 1) begin
                    checks++;
                    if (o_load_out !== 27'h0) begin
                        failures++;
                        $display("FAIL rst_load_out got=%h want=0", o_load_out);
                    end
                end
                ce = (n == div - 1);
                i_rst = ce && cyc == rst_at;
                @(posedge clk);
                #1;
            end
            ce = 1'b0;
            i_rst = 1'b0;
        end
        checks++;
        if (loads != want) begin
            failures++;
            $display("FAIL load_count got=%0d want=%0d", loads, want);
        end
    endtask

    task automatic set_basic(input bit en);
        fill_empty(8'h00);
        i_obj_size = 1'b0; i_pt_sel = 1'b1; i_sprites_enabled = en;
        ty[0] = 8'h03; tt[0] = 8'h42; ta[0] = 8'h00; tx[0] = 8'h10; dlo[0] = 8'h80; dhi[0] = 8'h01;
        erd[0] = en; ea0[0] = 14'h1423; ea1[0] = 14'h142B;
        eo[0] = en ? {8'h01, 8'h80, 8'h10, 3'b000} : {16'h0, 8'h10, 3'b000};
        ty[1] = 8'h02; tt[1] = 8'h10; ta[1] = 8'hE3; tx[1] = 8'h55; dlo[1] = 8'hC0; dhi[1] = 8'h05;
        erd[1] = en; ea0[1] = 14'h1105; ea1[1] = 14'h110D;
        eo[1] = en ? {8'hC0, 8'h05, 8'h55, 3'b111} : {16'h0, 8'h55, 3'b111};
    endtask

    task automatic test_reset();
        i_rst = 1'b1; ce = 1'b0; i_cycle = 9'd260; i_sprites_enabled = 1'b1;
        i_obj_size = 1'b0; i_pt_sel = 1'b1; i_oam_bus = 8'h00; i_vram_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (o_load !== 4'h0) begin failures++; $display("FAIL reset_load got=%h want=0", o_load); end
        checks++;
        if (o_load_out !== 27'h0) begin failures++; $display("FAIL reset_out got=%h want=0", o_load_out); end
        checks++;
        if (o_vram_rd !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b want=0", o_vram_rd); end
        checks++;
        if (o_vram_addr !== 14'h0) begin failures++; $display("FAIL reset_addr got=%h want=0", o_vram_addr); end
        i_rst = 1'b0;
    endtask

    task automatic test_basic_8x8();
        set_basic(1'b1);
        run_line(1, -1);
    endtask

    task automatic test_8x16();
        fill_empty(8'h00);
        i_obj_size = 1'b1; i_pt_sel = 1'b0; i_sprites_enabled = 1'b1;
        ty[0] = 8'h09; tt[0] = 8'h43; ta[0] = 8'h00; tx[0] = 8'h07; dlo[0] = 8'h0F; dhi[0] = 8'hAA;
        erd[0] = 1'b1; ea0[0] = 14'h1431; ea1[0] = 14'h1439;
        eo[0] = {8'hF0, 8'h55, 8'h07, 3'b000};
        ty[1] = 8'h02; tt[1] = 8'h43; ta[1] = 8'h80; tx[1] = 8'h30; dlo[1] = 8'h01; dhi[1] = 8'h00;
        erd[1] = 1'b1; ea0[1] = 14'h1435; ea1[1] = 14'h143D;
        eo[1] = {8'h80, 8'h00, 8'h30, 3'b000};
        run_line(1, -1);
    endtask

    task automatic test_all_empty();
        fill_empty(8'h21);
        i_obj_size = 1'b0; i_pt_sel = 1'b1; i_sprites_enabled = 1'b1;
        run_line(1, -1);
    endtask

    task automatic test_disabled();
        set_basic(1'b0);
        run_line(1, -1);
    endtask

    task automatic test_ce_slow();
        set_basic(1'b1);
        run_line(4, -1);
    endtask

    task automatic test_reset_mid_slot();
        fill_empty(8'h00);
        i_obj_size = 1'b0; i_pt_sel = 1'b0; i_sprites_enabled = 1'b1;
        for (int s = 0; s < 8; s++) begin
            ty[s] = 8'h01; tt[s] = 8'(s); ta[s] = 8'h40; tx[s] = 8'(16 * s);
            dlo[s] = 8'(s + 1); dhi[s] = 8'hF0 | 8'(s);
            erd[s] = (s != 3); eld[s] = (s != 3);
            ea0[s] = 14'(16 * s + 1); ea1[s] = 14'(16 * s + 9);
            eo[s] = {dlo[s], dhi[s], tx[s], 3'b000};
        end
        run_line(1, 283);
    endtask

    initial begin
        test_reset();
        test_basic_8x8();
        test_8x16();
        test_all_empty();
        test_disabled();
        test_ce_slow();
        test_reset_mid_slot();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sprite_fetch.md
SPRITE_FETCH -- requirements
Module: sprite_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, VRAM address width; values other than 14 are unsupported.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port ce  input  1  PPU cycle enable; all state changes except reset occur only on clk edges with ce=1.
REQ-005 SHALL have port i_cycle  input  9  current PPU cycle.
REQ-006 SHALL have port i_sprites_enabled  input  1  sprite rendering enable.
REQ-007 SHALL have port i_obj_size  input  1  1 = 8x16 sprites.
REQ-008 SHALL have port i_pt_sel  input  1  8x8 sprite pattern table select.
REQ-009 SHALL have port i_oam_bus  input  8  secondary-OAM byte presented by the sprite evaluator.
REQ-010 SHALL have port o_vram_addr  output  14  pattern fetch address.
REQ-011 SHALL have port o_vram_rd  output  1  pattern read strobe.
REQ-012 SHALL have port i_vram_data  input  8  pattern byte, valid one ce cycle after the read.
REQ-013 SHALL have port o_load  output  4  load mask to the sprite set.
REQ-014 SHALL have port o_load_out  output  27  {pix1[7:0], pix2[7:0], x[7:0], upper_color[1:0], aprio}.

Function
REQ-015 Fetch window: cycles 256-319; c = i_cycle-256, slot = c[5:3], k = c[2:0].
REQ-016 k=0: capture row = i_oam_bus[3:0]; empty = (i_oam_bus[7:4] != 0); set slot_valid.
REQ-017 k=1 capture tile, k=2 capture attrib, k=3 capture x, all from i_oam_bus.
REQ-018 Effective row: attrib[7]=1 -> 7-row (8x8) or 15-row (8x16), else row; 4-bit arithmetic.
REQ-019 Address 8x8: {0, i_pt_sel, tile[7:0], plane, erow[2:0]}; 8x16: {0, tile[0], tile[7:1], erow[3], plane, erow[2:0]}.
REQ-020 o_vram_rd, o_vram_addr combinational: k=4 plane 0, k=6 plane 1, only if slot_valid, !empty, i_sprites_enabled; otherwise o_vram_rd=0, o_vram_addr=0.
REQ-021 i_vram_data sampled at ce edge ending k=5 (low plane) and k=7 (high plane); plane forced 0 if no read issued in k=4/k=6.
REQ-022 Bit order: attrib[6]=0 -> byte bit-reversed (leftmost pixel to bit 0); attrib[6]=1 -> unchanged.
REQ-023 At ce edge ending k=7 with slot_valid: o_load<=4'b1111, o_load_out<={low, high, x, attrib[1:0], attrib[5]}; slot_valid cleared.
REQ-024 o_load registered, held until next ce edge, then 0; o_load_out holds last value.
REQ-025 Exactly 8 loads per line (cycles 264,272,...,320 see o_load); slot 0 loaded first, ending in sprite0.
REQ-026 Empty slot: load still issued, pix1=pix2=0, x and attrib from captured bytes.
REQ-027 Outside window: no capture, o_vram_rd=0, o_load=0 after the final slot load.
REQ-028 ce=0: all registers hold; combinational outputs follow held state.

Reset
REQ-029 i_rst: o_load=0, o_load_out=0, slot_valid=0, captured bytes=0; o_vram_rd=0 combinationally.
REQ-030 Reset mid-slot aborts that slot; no load until next complete k=0..7.
REQ-031 Reset dominates ce.

Verification
REQ-032 8x8, slot 0 Y=0x03 tile=0x42 attrib=0x00 x=0x10, pt_sel=1, data 0x80/0x01 -> addrs 0x1423/0x142B, o_load_out={0x01,0x80,0x10,00,0} at cycle 264.
REQ-033 attrib=0xE3 (vflip, hflip, prio, pal 3), 8x8 row 2 -> erow 5, bytes unreversed, o_load_out[2:0]=3'b111.
REQ-034 8x16 tile=0x43 row 0x9, vflip=0 -> addr 0x1431 (plane 0), 0x1439 (plane 1).
REQ-035 All eight slots Y=0xFF -> no o_vram_rd in window, eight loads with pix=0.
REQ-036 ce toggling every 4th clk -> identical load sequence, o_load high exactly one ce period each.
REQ-037 i_rst at cycle 283 (slot 3, k=3) -> slot 3 not loaded; slots 4-7 load normally.
